// File: rtl/vedic64x64_seq_accum.sv
// Sequential 64x64 unsigned multiplier: walks all 16 digit-pair products through one external
// 16x16 stage and accumulates the shifted partial products into a 128-bit result.
module vedic64x64_seq_accum (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  a_in,
  input  logic [63:0]  b_in,
  output logic [15:0]  mul_a,
  output logic [15:0]  mul_b,
  input  logic [31:0]  mul_p,
  output logic         busy,
  output logic         done,
  output logic [127:0] product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic [3:0]     r_idx;
  logic [63:0]    r_a;
  logic [63:0]    r_b;
  logic [127:0]   r_acc;

  logic [1:0]     w_i;
  logic [1:0]     w_j;
  logic [2:0]     w_pos;
  logic [6:0]     w_shamt;
  logic [127:0]   w_pp;

  // idx[1:0] selects the A digit, idx[3:2] the B digit; weight is 16*(i+j)
  assign w_i     = r_idx[1:0];
  assign w_j     = r_idx[3:2];
  assign w_pos   = {1'b0, w_i} + {1'b0, w_j};
  assign w_shamt = {w_pos, 4'b0000};
  assign w_pp    = {96'b0, mul_p} << w_shamt;

  assign product = r_acc;

  always_comb begin
    w_state_next = r_state;
    mul_a        = '0;
    mul_b        = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StRun;
      end
      StRun: begin
        busy  = 1'b1;
        mul_a = r_a[{w_i, 4'b0000} +: 16];
        mul_b = r_b[{w_j, 4'b0000} +: 16];
        if (r_idx == 4'd15) w_state_next = StDone;
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        StRun: begin
          r_acc <= r_acc + w_pp;
          r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
